mem_port_arb: RTL

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/mem_port_arb_pkg.sv | 28 ++
 rtl/mem_port_arb_rr_arbiter.sv | 30 +++
 rtl/mem_port_arb.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared constants for the memory port arbiter: size and state encodings,
// the IO address window tag and the size-to-byte-count decode.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // addr[17:16] value that routes a write to the IO sink
    localparam logic [1:0] IO_RANGE = 2'b11;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arb_rr_arbiter.sv
// Round-robin picker: first eligible port after ptr (wrapping), one-hot out.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    always_comb begin
        int               idx;
        logic             found;
        logic [PTR_W-1:0] sel;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int off = 1; off <= N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) idx = idx - N;
            sel = PTR_W'(idx);
            if (!found && eligible[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Multi-port byte-serial memory arbiter: round-robin grant of one request at a
// time, then a byte sequencer that drives the 8-bit RAM port for 1/2/4 bytes.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int                   NUM_PORTS  = 3,
    parameter int                   ADDR_W     = 32,
    parameter logic [NUM_PORTS-1:0] FLUSH_MASK = NUM_PORTS'(3'b011)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rdy,
    output logic [7:0]                    mem_din,
    input  logic [7:0]                    mem_dout,
    output logic [ADDR_W-1:0]             mem_a,
    output logic                          mem_wr,
    input  logic                          io_buffer_full,
    input  logic                          flush,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [2*NUM_PORTS-1:0]        req_size,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*32-1:0]       req_wdata,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [NUM_PORTS-1:0]          resp_valid,
    output logic [31:0]                   resp_data
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_PORTS - 1);

    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_v;
    logic [NUM_PORTS-1:0][1:0]        size_v;
    logic [NUM_PORTS-1:0][31:0]       wdata_v;

    assign addr_v  = req_addr;
    assign size_v  = req_size;
    assign wdata_v = req_wdata;

    state_e            state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  cur;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        nbytes;
    logic [2:0]        cnt;
    logic [31:0]       rd_buf;
    logic              mem_wr_q;

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;
    logic [PTR_W-1:0]     gidx;

    // IO-window writes wait out a full sink; abortable reads sit out a flush cycle
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_elig
        logic io_blk;
        logic fl_blk;
        assign io_blk      = req_we[i] && (addr_v[i][17:16] == IO_RANGE) && io_buffer_full;
        assign fl_blk      = flush && FLUSH_MASK[i] && !req_we[i];
        assign eligible[i] = req_valid[i] && !io_blk && !fl_blk;
    end

    rr_arbiter #(
        .N     (NUM_PORTS),
        .PTR_W (PTR_W)
    ) u_rr (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) gidx = PTR_W'(i);
        end
    end

    logic [2:0]        cnt_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [7:0]        wbyte_nx;
    logic [1:0]        cap_idx;
    logic [31:0]       rd_merged;

    assign cnt_nx   = cnt + 3'd1;
    assign addr_nx  = addr_q + ADDR_W'(cnt_nx);
    assign wbyte_nx = wdata_q[8*cnt_nx[1:0] +: 8];
    // RAM data lags the address by one cycle, so cycle cnt returns byte cnt-1
    assign cap_idx  = cnt[1:0] - 2'd1;

    always_comb begin
        rd_merged                 = rd_buf;
        rd_merged[8*cap_idx +: 8] = mem_dout;
    end

    // A stalled cycle must not repeat the byte currently on the bus
    assign mem_wr = mem_wr_q & rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= PTR_RST;
            cur        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            nbytes     <= '0;
            cnt        <= '0;
            rd_buf     <= '0;
            mem_a      <= '0;
            mem_din    <= '0;
            mem_wr_q   <= 1'b0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            if (rdy) begin
                case (state)
                    ST_IDLE: begin
                        if (|grant) begin
                            ptr       <= gidx;
                            cur       <= gidx;
                            addr_q    <= addr_v[gidx];
                            wdata_q   <= wdata_v[gidx];
                            nbytes    <= size_bytes(size_v[gidx]);
                            cnt       <= '0;
                            rd_buf    <= '0;
                            mem_a     <= addr_v[gidx];
                            mem_din   <= wdata_v[gidx][7:0];
                            mem_wr_q  <= req_we[gidx];
                            req_ready <= grant;
                            state     <= req_we[gidx] ? ST_WR : ST_RD;
                        end
                    end
                    ST_RD: begin
                        if (flush && FLUSH_MASK[cur]) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt_nx;
                            if (cnt_nx < nbytes) mem_a <= addr_nx;
                            if (cnt != 3'd0) rd_buf <= rd_merged;
                            if (cnt == nbytes) begin
                                resp_data       <= rd_merged;
                                resp_valid[cur] <= 1'b1;
                                state           <= ST_DONE;
                            end
                        end
                    end
                    ST_WR: begin
                        if (cnt_nx < nbytes) begin
                            cnt     <= cnt_nx;
                            mem_a   <= addr_nx;
                            mem_din <= wbyte_nx;
                        end else begin
                            mem_wr_q        <= 1'b0;
                            resp_valid[cur] <= 1'b1;
                            state           <= ST_DONE;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
